// File: rtl/rvfi_commit_serializer_if.sv
`default_nettype none
// ============================================================================
// rvfi_commit_serializer_if
//   Retire-side push bus and RVFI-side commit bus of the commit serializer.
//   Revision: 1.0
// ============================================================================
interface rvfi_commit_serializer_if #(
    parameter int PKT_W = 313
);
    logic [1:0]       in_valid;
    logic [PKT_W-1:0] in_pkt0;
    logic [PKT_W-1:0] in_pkt1;
    logic             in_ready;
    logic             rvfi_commit;
    logic [63:0]      rvfi_order;
    logic [PKT_W-1:0] out_pkt;
    logic             rvfi_halt;
    logic             pc_err;
    logic             lane_err;

    modport master (
        output in_valid, in_pkt0, in_pkt1,
        input  in_ready, rvfi_commit, rvfi_order, out_pkt, rvfi_halt, pc_err, lane_err
    );

    modport slave (
        input  in_valid, in_pkt0, in_pkt1,
        output in_ready, rvfi_commit, rvfi_order, out_pkt, rvfi_halt, pc_err, lane_err
    );
endinterface
`default_nettype wire

// File: rtl/rvfi_commit_serializer.sv
`default_nettype none
// ============================================================================
// rvfi_commit_serializer
//   Buffers up to two retired instructions per cycle and replays them one per
//   cycle as ordered RVFI commits with halt and PC-continuity detection.
//   Revision: 1.0
// ============================================================================
module rvfi_commit_serializer #(
    parameter int DEPTH = 8,
    parameter int PKT_W = 313
) (
    input  logic                     clk,
    input  logic                     rst,
    rvfi_commit_serializer_if.slave  bus
);
    localparam int          AW          = $clog2(DEPTH);
    localparam int          PW          = AW + 1;
    localparam logic [31:0] C_HALT_JAL  = 32'h0000006f;
    localparam logic [31:0] C_HALT_BEQ  = 32'h00000063;

    logic [PKT_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q;
    logic [PW-1:0]    wr_nxt;
    logic [PW-1:0]    occ;
    logic             empty;
    logic             pop;
    logic             we0, we1;
    logic             lane_err_q, lane_err_d;

    logic             commit_q;
    logic [63:0]      order_q;
    logic [63:0]      cnt_q;
    logic [PKT_W-1:0] pkt_q;
    logic             halt_q;
    logic             pc_err_q;
    logic             prev_vld_q;
    logic [31:0]      prev_pc_q;

    logic [PKT_W-1:0] head;
    logic [31:0]      head_inst, head_pcr, head_pcw;

    assign wr_nxt = wr_q + PW'(1);
    assign occ    = wr_q - rd_q;
    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty  = (wr_q[AW] == rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop    = !empty && !halt_q;

    assign head      = mem_q[rd_q[AW-1:0]];
    assign head_inst = head[PKT_W-1  -: 32];
    assign head_pcr  = head[PKT_W-33 -: 32];
    assign head_pcw  = head[PKT_W-65 -: 32];

    assign bus.in_ready    = (occ <= PW'(DEPTH - 2));
    assign bus.rvfi_commit = commit_q;
    assign bus.rvfi_order  = order_q;
    assign bus.out_pkt     = pkt_q;
    assign bus.rvfi_halt   = halt_q;
    assign bus.pc_err      = pc_err_q;
    assign bus.lane_err    = lane_err_q;

    always_comb begin
        wr_d       = wr_q;
        lane_err_d = lane_err_q;
        we0        = 1'b0;
        we1        = 1'b0;
        if (bus.in_ready) begin
            case (bus.in_valid)
                2'b01: begin
                    we0  = 1'b1;
                    wr_d = wr_nxt;
                end
                2'b11: begin
                    we0  = 1'b1;
                    we1  = 1'b1;
                    wr_d = wr_q + PW'(2);
                end
                2'b10:   lane_err_d = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (we0) mem_q[wr_q[AW-1:0]]   <= bus.in_pkt0;
        if (we1) mem_q[wr_nxt[AW-1:0]] <= bus.in_pkt1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q       <= '0;
            rd_q       <= '0;
            lane_err_q <= 1'b0;
            commit_q   <= 1'b0;
            order_q    <= '0;
            cnt_q      <= '0;
            pkt_q      <= '0;
            halt_q     <= 1'b0;
            pc_err_q   <= 1'b0;
            prev_vld_q <= 1'b0;
            prev_pc_q  <= '0;
        end else begin
            wr_q       <= wr_d;
            lane_err_q <= lane_err_d;
            commit_q   <= pop;
            if (pop) begin
                rd_q       <= rd_q + PW'(1);
                pkt_q      <= head;
                order_q    <= cnt_q;
                cnt_q      <= cnt_q + 64'd1;
                prev_vld_q <= 1'b1;
                prev_pc_q  <= head_pcw;
                if (head_inst == C_HALT_JAL || head_inst == C_HALT_BEQ)
                    halt_q <= 1'b1;
                if (prev_vld_q && head_pcr != prev_pc_q)
                    pc_err_q <= 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_rvfi_commit_serializer.sv
`default_nettype none
// ============================================================================
// tb_rvfi_commit_serializer
//   Randomised bench with a queue-based reference model and a commit scoreboard.
//   Revision: 1.0
// ============================================================================
module tb_rvfi_commit_serializer;
    localparam int DEPTH = 8;
    localparam int PKT_W = 313;

    typedef logic [PKT_W-1:0] pkt_t;
    typedef struct {
        pkt_t        pkt;
        logic [63:0] order;
        logic        halt;
        logic        pcerr;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rvfi_commit_serializer_if #(.PKT_W(PKT_W)) bus();

    rvfi_commit_serializer #(.DEPTH(DEPTH), .PKT_W(PKT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          passed = 0;
    exp_t        sb[$];
    pkt_t        mq[$];
    logic        halt_m, pcerr_m, lerr_m, prevv_m;
    logic [31:0] prevpc_m;
    logic [63:0] ord_m;
    logic [31:0] gen_pc;
    int          pushed_m;

    function automatic logic [31:0] f_inst(input pkt_t p); return p[PKT_W-1  -: 32]; endfunction
    function automatic logic [31:0] f_pcr (input pkt_t p); return p[PKT_W-33 -: 32]; endfunction
    function automatic logic [31:0] f_pcw (input pkt_t p); return p[PKT_W-65 -: 32]; endfunction

    function automatic logic [31:0] rnd_inst();
        logic [31:0] x;
        x = $urandom;
        if (x == 32'h6f || x == 32'h63) x = x ^ 32'h8000_0000;
        return x;
    endfunction

    function automatic pkt_t mk(input logic [31:0] inst, input logic [31:0] pcr, input logic [31:0] pcw);
        pkt_t p;
        for (int i = 0; i < PKT_W; i++) p[i] = 1'($urandom_range(0, 1));
        p[PKT_W-1  -: 32] = inst;
        p[PKT_W-33 -: 32] = pcr;
        p[PKT_W-65 -: 32] = pcw;
        return p;
    endfunction

    task automatic chk(input string name, input pkt_t act, input pkt_t exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // One clock of stimulus; the queue model decides acceptance, pops and expected commits.
    task automatic step(input logic r, input logic [1:0] v, input pkt_t p0, input pkt_t p1);
        bit   ready_m, pop_m;
        pkt_t h;
        exp_t e;
        @(negedge clk);
        rst          = r;
        bus.in_valid = v;
        bus.in_pkt0  = p0;
        bus.in_pkt1  = p1;
        ready_m = (DEPTH - mq.size()) >= 2;
        if (!r) begin
            chk("in_ready", pkt_t'(bus.in_ready), pkt_t'(ready_m));
            chk("lane_err", pkt_t'(bus.lane_err), pkt_t'(lerr_m));
        end
        @(posedge clk);
        pop_m = 0;
        if (r) begin
            mq.delete();
            halt_m = 0; pcerr_m = 0; lerr_m = 0; prevv_m = 0; prevpc_m = '0; ord_m = '0;
        end else begin
            if (mq.size() > 0 && !halt_m) begin
                h     = mq.pop_front();
                pop_m = 1;
                if (prevv_m && f_pcr(h) != prevpc_m) pcerr_m = 1;
                prevv_m  = 1;
                prevpc_m = f_pcw(h);
                if (f_inst(h) == 32'h6f || f_inst(h) == 32'h63) halt_m = 1;
                e.pkt = h; e.order = ord_m; e.halt = halt_m; e.pcerr = pcerr_m;
                sb.push_back(e);
                ord_m = ord_m + 64'd1;
            end
            if (ready_m) begin
                if (v == 2'b01) begin
                    mq.push_back(p0); gen_pc = f_pcw(p0); pushed_m += 1;
                end else if (v == 2'b11) begin
                    mq.push_back(p0); mq.push_back(p1); gen_pc = f_pcw(p1); pushed_m += 2;
                end else if (v == 2'b10) begin
                    lerr_m = 1;
                end
            end
        end
        #1;
        chk("commit_timing", pkt_t'(bus.rvfi_commit), pkt_t'(pop_m));
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 2'b00, '0, '0);
    endtask

    task automatic do_reset();
        step(1'b1, 2'b00, '0, '0);
    endtask

    task automatic chk_reset();
        chk("rst_commit",   pkt_t'(bus.rvfi_commit), '0);
        chk("rst_order",    pkt_t'(bus.rvfi_order),  '0);
        chk("rst_out_pkt",  bus.out_pkt,             '0);
        chk("rst_halt",     pkt_t'(bus.rvfi_halt),   '0);
        chk("rst_pc_err",   pkt_t'(bus.pc_err),      '0);
        chk("rst_lane_err", pkt_t'(bus.lane_err),    '0);
        chk("rst_in_ready", pkt_t'(bus.in_ready),    pkt_t'(1));
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && mq.size() > 0 && !halt_m; i++) idle(1);
        idle(2);
    endtask

    task automatic push_pair();
        pkt_t a, b;
        a = mk(rnd_inst(), gen_pc, gen_pc + 32'd4);
        b = mk(rnd_inst(), gen_pc + 32'd4, gen_pc + 32'd8);
        step(1'b0, 2'b11, a, b);
    endtask

    task automatic push_one();
        step(1'b0, 2'b01, mk(rnd_inst(), gen_pc, gen_pc + 32'd4), '0);
    endtask

    // Scoreboard monitor: every DUT commit must match the oldest expected commit.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.rvfi_commit === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_commit: got commit order %0d expected no commit", bus.rvfi_order);
                end else begin
                    e = sb.pop_front();
                    chk("sb_pkt",    bus.out_pkt,             e.pkt);
                    chk("sb_order",  pkt_t'(bus.rvfi_order),  pkt_t'(e.order));
                    chk("sb_halt",   pkt_t'(bus.rvfi_halt),   pkt_t'(e.halt));
                    chk("sb_pc_err", pkt_t'(bus.pc_err),      pkt_t'(e.pcerr));
                end
            end
        end
    end

    initial begin
        pkt_t pk[10];
        int   start;
        int   c;
        int   sel;
        rst = 1'b1;
        bus.in_valid = '0; bus.in_pkt0 = '0; bus.in_pkt1 = '0;
        halt_m = 0; pcerr_m = 0; lerr_m = 0; prevv_m = 0; prevpc_m = '0; ord_m = '0;
        gen_pc = 32'h60; pushed_m = 0;

        do_reset(); do_reset();
        chk_reset();

        // Three single-lane pushes back to back.
        gen_pc = 32'h60;
        repeat (3) push_one();
        idle(3);
        chk("t1_pc_err", pkt_t'(bus.pc_err),     '0);
        chk("t1_order",  pkt_t'(bus.rvfi_order), pkt_t'(2));

        // Dual pushes every cycle until backpressure, then drain.
        do_reset();
        gen_pc = 32'h1000;
        repeat (14) push_pair();
        drain();

        // Halt instruction at order 5 with more entries queued behind it.
        do_reset();
        gen_pc = 32'h200;
        for (int i = 0; i < 10; i++)
            pk[i] = mk((i == 5) ? 32'h0000006f : rnd_inst(), 32'h200 + 32'(4*i), 32'h204 + 32'(4*i));
        for (int k = 0; k < 5; k++) step(1'b0, 2'b11, pk[2*k], pk[2*k+1]);
        idle(8);
        chk("t3_halt",  pkt_t'(bus.rvfi_halt),  pkt_t'(1));
        chk("t3_order", pkt_t'(bus.rvfi_order), pkt_t'(5));

        // PC discontinuity on the second commit; emission continues.
        do_reset();
        step(1'b0, 2'b01, mk(rnd_inst(), 32'h60, 32'h64), '0);
        step(1'b0, 2'b01, mk(rnd_inst(), 32'h80, 32'h84), '0);
        step(1'b0, 2'b01, mk(rnd_inst(), 32'h84, 32'h88), '0);
        idle(4);
        chk("t4_pc_err", pkt_t'(bus.pc_err),     pkt_t'(1));
        chk("t4_order",  pkt_t'(bus.rvfi_order), pkt_t'(2));

        // Lane-1-only valid, then reset with entries still buffered.
        do_reset();
        gen_pc = 32'h400;
        step(1'b0, 2'b10, mk(rnd_inst(), 32'h400, 32'h404), mk(rnd_inst(), 32'h400, 32'h404));
        chk("t5_lane_err", pkt_t'(bus.lane_err), pkt_t'(1));
        idle(1);
        repeat (3) push_pair();
        do_reset();
        chk_reset();
        gen_pc = 32'h500;
        push_one();
        idle(3);
        chk("t5_order_restart", pkt_t'(bus.rvfi_order), '0);

        // Random 1/2-lane fill and drain of 3*DEPTH entries across pointer wrap.
        do_reset();
        gen_pc = 32'h8000;
        start = pushed_m;
        c = 0;
        while (pushed_m - start < 3 * DEPTH && c < 500) begin
            sel = $urandom_range(0, 3);
            if (sel == 0)      idle(1);
            else if (sel == 1) push_one();
            else               push_pair();
            c++;
        end
        drain();

        @(negedge clk);
        chk("sb_empty", pkt_t'(sb.size()), '0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
`default_nettype wire
